// File: rtl/irda_sir_encoder.sv
// SIR (IrDA 1.0) transmit encoder: UART-framed bytes, RZI pulse per 0 bit, timed by 16x baud tick.
// Optional `IRDA_SIR_FIXED_PULSE_EN: fixed PULSE_CLKS-wide pulses instead of PULSE_LEN baud ticks.
module irda_sir_encoder #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PULSE_START = 6,
    parameter int unsigned PULSE_LEN   = 3,
    parameter int unsigned PULSE_CLKS  = 77
) (
    input  logic       clk,
    input  logic       wb_rst_n,
    input  logic       sir_en,
    input  logic       sir_baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sir_enc_o,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int unsigned CntW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 2 || PULSE_START < 1 || PULSE_LEN < 1 ||
        PULSE_START + PULSE_LEN > OVERSAMPLE || PULSE_CLKS < 1) begin : g_param_check
        $error("irda_sir_encoder: inconsistent pulse parameters");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cur_bit;

    assign tx_ready   = wb_rst_n && sir_en && (state_q == StIdle);
    assign tx_busy    = busy_q;
    assign frame_done = done_q;

    // Level of the frame bit currently being sent; idle line reads as a 1 (no pulse).
    always_comb begin
        cur_bit = 1'b1;
        unique case (state_q)
            StStart: cur_bit = 1'b0;
            StData:  cur_bit = shift_q[0];
            default: cur_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (!sir_en) begin
            // Abort: drop the frame silently, no frame_done.
            state_d = StIdle;
            tick_d  = '0;
            bit_d   = '0;
            shift_d = '0;
            busy_d  = 1'b0;
        end else if (state_q == StIdle) begin
            if (tx_valid) begin
                state_d = StStart;
                tick_d  = '0;
                bit_d   = '0;
                shift_d = tx_data;
                busy_d  = 1'b1;
            end
        end else if (sir_baud_tick) begin
            if (tick_q != LastTick) begin
                tick_d = tick_q + 1'b1;
            end else begin
                tick_d = '0;
                if (state_q == StStart) begin
                    state_d = StData;
                    bit_d   = '0;
                end else if (state_q == StData) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef IRDA_SIR_FIXED_PULSE_EN
    localparam int unsigned PulseW = $clog2(PULSE_CLKS + 1);

    logic [PulseW-1:0] pulse_q, pulse_d;

    // Load when a 0 bit's tick count is about to become PULSE_START.
    always_comb begin
        pulse_d = pulse_q;
        if (!sir_en) begin
            pulse_d = '0;
        end else if (sir_baud_tick && !cur_bit && (tick_q == CntW'(PULSE_START - 1))) begin
            pulse_d = PulseW'(PULSE_CLKS);
        end else if (pulse_q != '0) begin
            pulse_d = pulse_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign sir_enc_o = (pulse_q != '0);
`else
    logic enc_q, enc_d;
    logic in_window;

    assign in_window = (tick_q >= CntW'(PULSE_START)) &&
                       (tick_q <= CntW'(PULSE_START + PULSE_LEN - 1));

    always_comb begin
        enc_d = sir_en && !cur_bit && in_window;
    end

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            enc_q <= 1'b0;
        end else begin
            enc_q <= enc_d;
        end
    end

    assign sir_enc_o = enc_q;
`endif

endmodule

// File: tb/tb_irda_sir_encoder.sv
// Randomized self-checking bench for irda_sir_encoder against a tick-level frame model.
module tb_irda_sir_encoder;

    localparam int OS = 16;
    localparam int PS = 6;
    localparam int PL = 3;
    localparam int PC = 77;
`ifdef IRDA_SIR_FIXED_PULSE_EN
    localparam int DirPeriod = 26;
`else
    localparam int DirPeriod = 4;
`endif

    logic       clk = 1'b0;
    logic       wb_rst_n, sir_en, sir_baud_tick, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, sir_enc_o, tx_busy, frame_done;

    irda_sir_encoder #(
        .OVERSAMPLE (OS),
        .PULSE_START(PS),
        .PULSE_LEN  (PL),
        .PULSE_CLKS (PC)
    ) dut (
        .clk          (clk),
        .wb_rst_n     (wb_rst_n),
        .sir_en       (sir_en),
        .sir_baud_tick(sir_baud_tick),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .sir_enc_o    (sir_enc_o),
        .tx_busy      (tx_busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a frame is 10 bits of OS ticks; m_n counts ticks since accept.
    logic       m_active = 1'b0;
    int         m_n = 0;
    int         m_p = 0;
    logic [7:0] m_byte = 8'h00;

    // Observation state for frame-level checks.
    int         cyc = 0;
    int         tick_period = 4;
    logic       prev_enc = 1'b0;
    int         pulses = 0;
    int         pulse_w = 0;
    int         frame_ticks = 0;
    logic [7:0] obs_byte = 8'h00;
    int         last_done_cyc = 0;
    int         last_accept_cyc = 0;
    logic       seen_done = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    task automatic cycle();
        logic       exp_enc, exp_done, pre_busy, pre_tick;
        logic [7:0] pre_data;
        int         pos;
        if (tick_period > 0) sir_baud_tick = ((cyc % tick_period) == 0);
        else sir_baud_tick = ($urandom_range(0, 2) == 0);
        #1;
        check_eq("tx_ready", tx_ready, !m_active && sir_en);
        pre_busy = tx_busy;
        pre_data = tx_data;
        pre_tick = sir_baud_tick;
        exp_done = 1'b0;
        pos = m_n % OS;
        exp_enc = sir_en && m_active && !frame_bit(m_byte, m_n / OS) && pos >= PS && pos < PS + PL;
        if (!sir_en) begin
            m_active = 1'b0;
            m_n = 0;
            m_p = 0;
        end else begin
            if (m_p > 0) m_p--;
            if (!m_active) begin
                if (tx_valid) begin
                    m_active = 1'b1;
                    m_n = 0;
                    m_byte = tx_data;
                end
            end else if (sir_baud_tick) begin
                m_n++;
                if (m_n == 10 * OS) begin
                    m_active = 1'b0;
                    m_n = 0;
                    exp_done = 1'b1;
                end else if ((m_n % OS) == PS && !frame_bit(m_byte, m_n / OS)) begin
                    m_p = PC;
                end
            end
        end
`ifdef IRDA_SIR_FIXED_PULSE_EN
        exp_enc = (m_p != 0);
`endif
        @(posedge clk);
        cyc++;
        #1;
        check_eq("sir_enc_o", sir_enc_o, exp_enc);
        check_eq("tx_busy", tx_busy, m_active);
        check_eq("frame_done", frame_done, exp_done);
        if (!pre_busy && tx_busy) begin
            pulses = 0;
            frame_ticks = 0;
            obs_byte = pre_data;
            last_accept_cyc = cyc;
        end else if (pre_busy && pre_tick) begin
            frame_ticks++;
        end
        if (sir_enc_o && !prev_enc) begin
            pulses++;
            pulse_w = 0;
        end
        if (sir_enc_o) pulse_w++;
        if (!sir_enc_o && prev_enc && tx_busy && tick_period > 0) begin
`ifdef IRDA_SIR_FIXED_PULSE_EN
            check_eq("pulse_width", pulse_w, PC);
`else
            check_eq("pulse_width", pulse_w, PL * tick_period);
`endif
        end
        if (frame_done) begin
            seen_done = 1'b1;
            last_done_cyc = cyc;
            check_eq("frame_ticks", frame_ticks, 10 * OS);
            check_eq("pulse_count", pulses, 1 + 8 - $countones(obs_byte));
        end
        prev_enc = sir_enc_o;
    endtask

    task automatic send(input logic [7:0] b);
        int guard = 0;
        tx_valid = 1'b1;
        tx_data = b;
        while (!m_active && guard < 2000) begin
            cycle();
            guard++;
        end
        check_eq("accept_timeout", guard < 2000, 1'b1);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (m_active && guard < 20000) begin
            cycle();
            guard++;
        end
        check_eq("frame_timeout", guard < 20000, 1'b1);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_n = 0;
        m_p = 0;
        prev_enc = 1'b0;
    endtask

    initial begin
        int guard;
        wb_rst_n = 1'b0;
        sir_en = 1'b1;
        sir_baud_tick = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        #17;
        check_eq("rst_tx_ready", tx_ready, 1'b0);
        check_eq("rst_enc", sir_enc_o, 1'b0);
        check_eq("rst_busy", tx_busy, 1'b0);
        check_eq("rst_done", frame_done, 1'b0);
        @(negedge clk);
        wb_rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", tx_ready, 1'b1);

        tick_period = DirPeriod;
        send(8'h55);
        wait_idle();
        send(8'hFF);
        wait_idle();
        send(8'h00);
        wait_idle();

        // Back-to-back with tx_valid held across frame_done.
        tx_valid = 1'b1;
        tx_data = 8'hA3;
        guard = 0;
        while (!m_active && guard < 100) begin cycle(); guard++; end
        tx_data = 8'h3C;
        seen_done = 1'b0;
        guard = 0;
        while (!seen_done && guard < 20000) begin cycle(); guard++; end
        cycle();
        check_eq("b2b_gap", last_accept_cyc - last_done_cyc, 1);
        tx_valid = 1'b0;
        wait_idle();

        // Abort during data bit 4 (frame bit 5).
        send(8'h00);
        guard = 0;
        while (m_n < OS * 5 + 7 && guard < 20000) begin cycle(); guard++; end
        sir_en = 1'b0;
        cycle();
        check_eq("abort_busy", tx_busy, 1'b0);
        check_eq("abort_enc", sir_enc_o, 1'b0);
        sir_en = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        send(8'h96);
        wait_idle();

        for (int f = 0; f < 30; f++) begin
`ifdef IRDA_SIR_FIXED_PULSE_EN
            tick_period = 26 + int'($urandom_range(0, 4));
`else
            tick_period = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
`endif
            for (int g = int'($urandom_range(0, 5)); g > 0; g--) cycle();
            send(8'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                for (int g = int'($urandom_range(1, 400)); g > 0 && m_active; g--) cycle();
                sir_en = 1'b0;
                cycle();
                sir_en = 1'b1;
            end
            wait_idle();
        end

        // Asynchronous reset while a pulse is being driven.
        tick_period = DirPeriod;
        send(8'h00);
        guard = 0;
        while (!sir_enc_o && guard < 5000) begin cycle(); guard++; end
        check_eq("pulse_before_reset", sir_enc_o, 1'b1);
        #2;
        wb_rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_enc", sir_enc_o, 1'b0);
        check_eq("async_rst_busy", tx_busy, 1'b0);
        check_eq("async_rst_done", frame_done, 1'b0);
        check_eq("async_rst_ready", tx_ready, 1'b0);
        @(negedge clk);
        wb_rst_n = 1'b1;
        #1;
        check_eq("async_rel_ready", tx_ready, 1'b1);
        send(8'h5A);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
